simple_splitter: RTL

Width-down converter that splits each 2*WIDTH_DOUT-bit input word into two WIDTH_DOUT-bit output words, first half first, with ready/valid flow control on both sides. It is the inverse of the simple_adapter packing stage and sits directly downstream of it, restoring the narrow byte stream for narrow consumers. Odd-length frames are supported through a half-valid tag on the last wide word.

---
 rtl/simple_splitter_pkg.sv | 14 +
 rtl/simple_splitter.sv | 94 +++++++++
 2 files changed

// File: rtl/simple_splitter_pkg.sv
// Shared types and defaults for simple_splitter: FSM state encoding and the
// default narrow/wide word widths.
package simple_splitter_pkg;

    localparam int DEF_WIDTH_DOUT = 8;
    localparam int DEF_WIDTH_DIN  = 2 * DEF_WIDTH_DOUT;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

endpackage

// File: rtl/simple_splitter.sv
// Width-down converter: one 2*WIDTH_DOUT word in, two WIDTH_DOUT words out.
// Optional macro SIMPLE_SPLITTER_LSB_FIRST_EN emits the lower half first.
module simple_splitter
    import simple_splitter_pkg::*;
#(
    parameter int WIDTH_DOUT = DEF_WIDTH_DOUT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din_vld,
    output logic                    din_rdy,
    input  logic [2*WIDTH_DOUT-1:0] din,
    input  logic                    din_last,
    input  logic                    din_half,
    output logic                    dout_vld,
    input  logic                    dout_rdy,
    output logic [WIDTH_DOUT-1:0]   dout,
    output logic                    dout_last
);

    localparam int WIDTH_DIN = 2 * WIDTH_DOUT;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH_DIN-1:0]   hold_data;
    logic                   hold_last;
    logic                   hold_half;
    logic                   run;
    logic [WIDTH_DOUT-1:0]  first_half;
    logic [WIDTH_DOUT-1:0]  second_half;
    logic                   out_xfer;
    logic                   word_end;
    logic                   in_xfer;

`ifdef SIMPLE_SPLITTER_LSB_FIRST_EN
    assign first_half  = hold_data[WIDTH_DOUT-1:0];
    assign second_half = hold_data[WIDTH_DIN-1:WIDTH_DOUT];
`else
    assign first_half  = hold_data[WIDTH_DIN-1:WIDTH_DOUT];
    assign second_half = hold_data[WIDTH_DOUT-1:0];
`endif

    assign dout_vld  = (state != EMPTY);
    assign out_xfer  = dout_vld && dout_rdy;
    assign word_end  = out_xfer && ((state == SECOND) || ((state == FIRST) && hold_half));
    // run keeps din_rdy low through reset without a combinational path from rstn.
    assign din_rdy   = run && ((state == EMPTY) || word_end);
    assign in_xfer   = din_vld && din_rdy;
    assign dout_last = hold_last && ((state == SECOND) || ((state == FIRST) && hold_half));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dout      = '0;
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (in_xfer) state_nxt = FIRST;
            end
            FIRST: begin
                dout = first_half;
                if (out_xfer) begin
                    if (hold_half) state_nxt = in_xfer ? FIRST : EMPTY;
                    else           state_nxt = SECOND;
                end
            end
            SECOND: begin
                dout = second_half;
                if (out_xfer) state_nxt = in_xfer ? FIRST : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rstn) begin
            state     <= EMPTY;
            run       <= 1'b0;
            // NOTE: the holding register is reset too, so dout reads 0 and nothing stale survives a mid-word reset.
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_half <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (in_xfer) begin
                hold_data <= din;
                hold_last <= din_last;
                hold_half <= din_half && din_last;
            end
        end
    end

endmodule
